sub_result_stage: RTL and testbench
===================================

Name: sub_result_stage

Overview:
- Registered output stage directly downstream of the 16-bit signed subtractor.
- Captures difference/overflow through a 2-entry valid/ready skid buffer and derives zero/negative flags.
- Maintains a sticky overflow flag and an accepted-result counter for the Lab1 datapath.
- No combinational path from in_* to out_*.

Parameters:
- WIDTH, 16, data width of difference path.
- CNT_WIDTH, 16, width of accepted-result counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept; 1 when fewer than 2 entries held
- in_difference  input  WIDTH  subtractor difference
- in_overflow  input  1  subtractor overflow
- in_a_msb  input  1  sign bit of minuend a (used for saturation)
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head
- out_difference  output  WIDTH  head difference
- out_overflow  output  1  head overflow
- out_zero  output  1  head difference == 0
- out_negative  output  1  head difference MSB
- clr_sticky  input  1  synchronous clear of sticky_ovf
- sticky_ovf  output  1  set by any accepted overflow result
- accept_count  output  CNT_WIDTH  number of accepted inputs, modulo 2^CNT_WIDTH

Behaviour:
- Reset (rst_n low, async): state EMPTY, both entries cleared.
  - out_valid=0, out_difference=0, out_overflow=0, out_zero=0, out_negative=0.
  - sticky_ovf=0, accept_count=0.
  - in_ready=1, since it is derived from state.
- push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated on the same edge.
- Entry contents {difference, overflow, zero, negative}. zero/negative are computed at capture from the stored difference.
- States:
  - EMPTY: in_ready=1, out_valid=0. push → ONE (head=input).
  - ONE: in_ready=1, out_valid=1.
    - push&!pop → TWO (tail=input).
    - pop&!push → EMPTY.
    - push&pop → ONE (head=input).
    - neither → hold.
  - TWO: in_ready=0, out_valid=1.
    - pop → ONE (head=tail).
    - in_valid ignored.
- Latency: input pushed at edge N appears on out_* immediately after edge N when the buffer was EMPTY. Minimum latency is 1 cycle.
- Order strictly FIFO; no entry dropped or duplicated.
- out_* hold stable while out_valid=1 and out_ready=0.
- sticky_ovf:
  - Set on push with stored overflow=1.
  - Cleared by clr_sticky.
  - If set and clear occur in the same cycle, set wins.
- accept_count increments by 1 on each push and wraps from all-ones to 0.
- Reset asserted mid-transfer discards all entries; no output is presented after reset release until a new push.
- Unknown/illegal state encoding → EMPTY.

Optional Feature:
- Macro SUB_RESULT_SATURATE_EN.
- Defined: on push with in_overflow=1, stored difference = in_a_msb ? 16'h8000 : 16'h7FFF (generally MSB-only / all-but-MSB for WIDTH).
  - overflow bit still stored as 1.
  - zero/negative are computed from the saturated value.
- Undefined: raw wrapped in_difference stored unchanged; in_a_msb unused.

Test Plan:
1. Reset then single push of diff=16'h0000, ovf=0 with out_ready=1.
   - Next cycle: out_valid=1, out_zero=1, out_negative=0.
   - Following cycle: out_valid=0 and accept_count=1.
2. out_ready=0, push 16'h0005 then 16'hFFFE.
   - in_ready drops to 0 after the second push; a third in_valid is ignored and accept_count stays 2.
   - Raising out_ready yields 0005 then FFFE (out_negative=1) in order.
3. Buffer in ONE, push 16'h1234 while popping head 16'h0001 each cycle for 4 cycles.
   - State stays ONE.
   - Outputs track inputs one cycle delayed, no gaps.
4. Push with in_overflow=1, in_a_msb=0, diff=16'h8001.
   - sticky_ovf=1 afterwards.
   - Without macro: out_difference=8001, out_negative=1.
   - With SUB_RESULT_SATURATE_EN: out_difference=7FFF, out_negative=0, out_overflow=1.
5. clr_sticky=1 in the same cycle as an overflow push → sticky_ovf stays 1. clr_sticky alone next cycle → 0.
6. Counter wrap: accept_count preloaded to FFFF via 65535 pushes, one more push gives 0000.
   - Then assert rst_n=0 mid-stream with 2 entries held → out_valid=0 and in_ready=1 immediately.

Source files
------------

// File: rtl/sub_result_stage.sv
// Registered result stage behind the 16-bit signed subtractor: 2-entry skid buffer,
// zero/negative flags, sticky overflow and accepted-result counter. Optional macro: SUB_RESULT_SATURATE_EN.
module sub_result_stage #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_difference,
   input  logic                 in_overflow,
   input  logic                 in_a_msb,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_difference,
   output logic                 out_overflow,
   output logic                 out_zero,
   output logic                 out_negative,
   input  logic                 clr_sticky,
   output logic                 sticky_ovf,
   output logic [CNT_WIDTH-1:0] accept_count,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] difference;
      logic             overflow;
      logic             zero;
      logic             negative;
   } entry_t;

   state_t           state;
   entry_t           head;
   entry_t           tail;
   entry_t           in_entry;
   logic [WIDTH-1:0] stored_diff;
   logic             push;
   logic             pop;

   // Handshake: a beat transfers on a side only in a cycle where both valid and ready
   // are high at the rising edge; in_ready/out_valid depend only on registered state.
   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

`ifdef SUB_RESULT_SATURATE_EN
   always_comb begin
      stored_diff = in_difference;
      if (in_overflow) begin
         stored_diff = in_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   logic unused_a_msb;
   assign unused_a_msb = in_a_msb;
   assign stored_diff  = in_difference;
`endif

   always_comb begin
      in_entry            = '0;
      in_entry.difference = stored_diff;
      in_entry.overflow   = in_overflow;
      in_entry.zero       = (stored_diff == '0);
      in_entry.negative   = stored_diff[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         head      <= '0;
         tail      <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  head      <= in_entry;
                  state     <= ONE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b1;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  tail      <= in_entry;
                  state     <= TWO;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
               end else if (pop && !push) begin
                  state     <= EMPTY;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end else if (push && pop) begin
                  head <= in_entry;
               end
            end
            TWO: begin
               if (pop) begin
                  head      <= tail;
                  state     <= ONE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b1;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Set has priority over a coincident clear so no overflow event is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_ovf <= 1'b0;
      end else if (push && in_entry.overflow) begin
         sticky_ovf <= 1'b1;
      end else if (clr_sticky) begin
         sticky_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accept_count <= '0;
      end else if (push) begin
         accept_count <= accept_count + 1'b1;
      end
   end

   assign out_difference = head.difference;
   assign out_overflow   = head.overflow;
   assign out_zero       = head.zero;
   assign out_negative   = head.negative;
   assign state_dbg      = state;

endmodule

// File: tb/tb_sub_result_stage.sv
// Directed bench for sub_result_stage: vector table plus hand sequences for
// backpressure, streaming, sticky priority, counter wrap and mid-stream reset.
module tb_sub_result_stage;

   localparam int W = 16;
   localparam int C = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_difference;
   logic          in_overflow;
   logic          in_a_msb;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_difference;
   logic          out_overflow;
   logic          out_zero;
   logic          out_negative;
   logic          clr_sticky;
   logic          sticky_ovf;
   logic [C-1:0]  accept_count;
   logic [1:0]    state_dbg;

   int total = 0;
   int bad   = 0;
   logic [C-1:0] exp_count = '0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [W-1:0] diff;
      logic         ovf;
      logic         a_msb;
      logic [W-1:0] e_diff;
      logic         e_ovf;
      logic         e_zero;
      logic         e_neg;
   } vec_t;

   vec_t vecs[7];

   sub_result_stage #(.WIDTH(W), .CNT_WIDTH(C)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_difference(in_difference), .in_overflow(in_overflow), .in_a_msb(in_a_msb),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_difference(out_difference), .out_overflow(out_overflow),
      .out_zero(out_zero), .out_negative(out_negative),
      .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf),
      .accept_count(accept_count), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic o, input logic m);
      in_valid      = v;
      in_difference = d;
      in_overflow   = o;
      in_a_msb      = m;
   endtask

   initial begin
      vecs[0] = '{16'h8001, 1'b1, 1'b0, 16'h8001, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{16'h7FFF, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1};
`ifdef SUB_RESULT_SATURATE_EN
      vecs[0] = '{16'h8001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{16'h7FFF, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{16'h0000, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1};
`endif

      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      out_ready  = 1'b0;
      clr_sticky = 1'b0;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_diff", 32'(out_difference), 32'd0);
      check("rst_flags", {out_overflow, out_zero, out_negative}, 32'd0);
      check("rst_sticky", 32'(sticky_ovf), 32'd0);
      check("rst_count", 32'(accept_count), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      rst_n = 1'b1;

      // single push through an empty buffer
      out_ready = 1'b1;
      drive(1'b1, 16'h0000, 1'b0, 1'b0);
      tick(); exp_count++;
      drive(1'b0, '0, 1'b0, 1'b0);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_zero", 32'(out_zero), 32'd1);
      check("t1_neg", 32'(out_negative), 32'd0);
      tick();
      check("t1_valid_after", 32'(out_valid), 32'd0);
      check("t1_count", 32'(accept_count), 32'(exp_count));

      // backpressure fills both entries; third beat must be ignored
      out_ready = 1'b0;
      drive(1'b1, 16'h0005, 1'b0, 1'b0); tick(); exp_count++;
      drive(1'b1, 16'hFFFE, 1'b0, 1'b0); tick(); exp_count++;
      check("t2_in_ready", 32'(in_ready), 32'd0);
      check("t2_state_two", 32'(state_dbg), 32'd2);
      drive(1'b1, 16'h7777, 1'b0, 1'b0); tick();
      check("t2_count_hold", 32'(accept_count), 32'(exp_count));
      check("t2_head_stable", 32'(out_difference), 32'h0005);
      drive(1'b0, '0, 1'b0, 1'b0);
      out_ready = 1'b1;
      tick();
      check("t2_second", 32'(out_difference), 32'hFFFE);
      check("t2_second_neg", 32'(out_negative), 32'd1);
      check("t2_second_valid", 32'(out_valid), 32'd1);
      tick();
      check("t2_drained", 32'(out_valid), 32'd0);

      // streaming in ONE: push and pop every cycle
      out_ready = 1'b0;
      drive(1'b1, 16'h0001, 1'b0, 1'b0); tick(); exp_count++;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'h1234 + 16'(i), 1'b0, 1'b0);
         tick(); exp_count++;
         check("t3_state_one", 32'(state_dbg), 32'd1);
         check("t3_track", 32'(out_difference), 32'h1234 + 32'(i));
         check("t3_valid", 32'(out_valid), 32'd1);
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      tick();
      check("t3_empty", 32'(out_valid), 32'd0);

      // vector table
      clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
      begin
         logic exp_sticky;
         exp_sticky = 1'b0;
         for (int i = 0; i < 7; i++) begin
            out_ready = 1'b0;
            drive(1'b1, vecs[i].diff, vecs[i].ovf, vecs[i].a_msb);
            tick(); exp_count++;
            exp_sticky = exp_sticky | vecs[i].ovf;
            drive(1'b0, '0, 1'b0, 1'b0);
            check("vec_valid", 32'(out_valid), 32'd1);
            check("vec_diff", 32'(out_difference), 32'(vecs[i].e_diff));
            check("vec_ovf", 32'(out_overflow), 32'(vecs[i].e_ovf));
            check("vec_zero", 32'(out_zero), 32'(vecs[i].e_zero));
            check("vec_neg", 32'(out_negative), 32'(vecs[i].e_neg));
            check("vec_sticky", 32'(sticky_ovf), 32'(exp_sticky));
            out_ready = 1'b1;
            tick();
         end
      end
      check("vec_count", 32'(accept_count), 32'(exp_count));

      // sticky: set beats a coincident clear, plain clear works
      clr_sticky = 1'b1;
      drive(1'b1, 16'h4000, 1'b1, 1'b1);
      tick(); exp_count++;
      drive(1'b0, '0, 1'b0, 1'b0);
      check("t5_set_wins", 32'(sticky_ovf), 32'd1);
      tick();
      clr_sticky = 1'b0;
      check("t5_cleared", 32'(sticky_ovf), 32'd0);
      check("t5_empty", 32'(out_valid), 32'd0);

      // long stream up to counter wrap, scoreboard on data order
      out_ready = 1'b1;
      while (exp_count != {C{1'b1}}) begin
         logic [W-1:0] d;
         d = W'($urandom_range(0, 65535));
         drive(1'b1, d, 1'b0, 1'b0);
         exp_q.push_back(d);
         tick(); exp_count++;
         if (out_valid !== 1'b1 || out_difference !== exp_q[0]) begin
            check("t6_stream", {15'd0, out_valid, out_difference}, {15'd0, 1'b1, exp_q[0]});
         end else begin
            total++;
         end
         void'(exp_q.pop_front());
      end
      check("t6_count_max", 32'(accept_count), 32'h0000FFFF);
      drive(1'b1, 16'h00AA, 1'b0, 1'b0);
      tick(); exp_count++;
      check("t6_count_wrap", 32'(accept_count), 32'd0);
      check("t6_wrap_data", 32'(out_difference), 32'h00AA);

      // fill both entries, then async reset mid-cycle
      out_ready = 1'b0;
      drive(1'b1, 16'h0B0B, 1'b0, 1'b0); tick();
      check("t6_full", 32'(state_dbg), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_ready", 32'(in_ready), 32'd1);
      check("t6_rst_count", 32'(accept_count), 32'd0);
      drive(1'b0, '0, 1'b0, 1'b0);
      out_ready = 1'b1;
      #1 rst_n = 1'b1;
      tick();
      check("t6_post_rst_valid", 32'(out_valid), 32'd0);
      tick();
      check("t6_post_rst_state", 32'(state_dbg), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
